// File: rtl/apb_arb_pkg.sv
// Shared types for the AHB-to-APB bridge port arbiter: FSM state encoding and error codes.
package apb_arb_pkg;

  // Arbiter FSM states, encoded IDLE=0, ISSUE=1, WAIT=2, RESP=3
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Value presented on err_o during RESP
  localparam logic ErrNone    = 1'b0;
  localparam logic ErrTimeout = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from (last+1) mod NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       valid_o,
  output logic [$clog2(NUM_REQ)-1:0] win_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned cand;

  // Walk the ring from farthest to nearest so the nearest pending requester is the final assignment
  always_comb begin
    valid_o = |req_i;
    win_o   = '0;
    cand    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(last_i) + i) % NUM_REQ;
      if (req_i[cand]) begin
        win_o = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-lite slave port of the AHB-to-APB bridge among NUM_REQ
// requesters. One single-word transfer in flight at a time.
// Optional build macro ARB_TIMEOUT_EN: aborts a WAIT that lasts TIMEOUT_CYCLES cycles, reporting
// err_o=1 with rdata_o=0. Without it WAIT may last forever and err_o is tied low.
module apb_bridge_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            write_i,
  input  logic [NUM_REQ*32-1:0]         wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [31:0]                   rdata_o,
  output logic                          err_o,
  output logic                          hsel_o,
  output logic                          hready_o,
  output logic [ADDR_WIDTH-1:0]         haddr_o,
  output logic                          hwrite_o,
  output logic [31:0]                   hwdata_o,
  input  logic                          hready_i,
  input  logic [31:0]                   hrdata_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e            state_q;
  logic [IdxW-1:0]       win_q;
  logic [IdxW-1:0]       last_q;
  logic                  first_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [31:0]           rdata_q;
  logic                  hsel_q;
  logic                  hready_q;

  logic                  pick_valid;
  logic [IdxW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [NUM_REQ-1:0]    win_oh;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] tmo_cnt_q;
  logic            err_q;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .win_o   (pick_idx)
  );

  assign pick_oh = NUM_REQ'(1) << pick_idx;
  assign win_oh  = NUM_REQ'(1) << win_q;

  // Arbiter FSM; every output is a register loaded for the state being entered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      win_q     <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      first_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      hsel_q    <= 1'b0;
      hready_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= ErrNone;
`endif
    end else begin
      // Single-cycle strobes default low
      hsel_q   <= 1'b0;
      hready_q <= 1'b0;
      done_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            win_q    <= pick_idx;
            addr_q   <= addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            write_q  <= write_i[pick_idx];
            wdata_q  <= wdata_i[int'(pick_idx)*32 +: 32];
            gnt_q    <= pick_oh;
            hsel_q   <= 1'b1;
            hready_q <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          first_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q   <= StWait;
        end
        StWait: begin
          first_q <= 1'b0;
          // The bridge's hready in the first WAIT cycle still belongs to its previous phase
          if (!first_q && hready_i) begin
            rdata_q <= write_q ? 32'd0 : hrdata_i;
            done_q  <= win_oh;
            state_q <= StResp;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= 32'd0;
            err_q   <= ErrTimeout;
            done_q  <= win_oh;
            state_q <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          gnt_q   <= '0;
          rdata_q <= 32'd0;
          last_q  <= win_q;
`ifdef ARB_TIMEOUT_EN
          err_q   <= ErrNone;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign hsel_o   = hsel_q;
  assign hready_o = hready_q;
  assign haddr_o  = addr_q;
  assign hwrite_o = write_q;
  assign hwdata_o = wdata_q;
`ifdef ARB_TIMEOUT_EN
  assign err_o    = err_q;
`else
  assign err_o    = ErrNone;
`endif

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter; the bench itself plays the bridge on hready_i/hrdata_i.
module tb_apb_bridge_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  req_i;
  logic [31:0] addr_i;
  logic [3:0]  write_i;
  logic [127:0] wdata_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        hsel_o;
  logic        hready_o;
  logic [7:0]  haddr_o;
  logic        hwrite_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic [31:0] hrdata_i;

  logic [7:0]  t_addr [4];
  logic        t_wr   [4];
  logic [31:0] t_wd   [4];

  int n_vec = 0;
  int n_err = 0;

  assign addr_i  = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
  assign write_i = {t_wr[3], t_wr[2], t_wr[1], t_wr[0]};
  assign wdata_i = {t_wd[3], t_wd[2], t_wd[1], t_wd[0]};

  always #5 clk_i = ~clk_i;

  apb_bridge_arbiter #(
    .NUM_REQ        (4),
    .ADDR_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .write_i  (write_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .hsel_o   (hsel_o),
    .hready_o (hready_o),
    .haddr_o  (haddr_o),
    .hwrite_o (hwrite_o),
    .hwdata_o (hwdata_o),
    .hready_i (hready_i),
    .hrdata_i (hrdata_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {12'd0, gnt_o, done_o, err_o, hsel_o, hready_o, hwrite_o, haddr_o}, 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_hwdata"}, hwdata_o, 32'd0);
  endtask

  // One full transaction for expected winner w; the bridge answers rd after dly extra WAIT cycles
  task automatic serve(input int w, input logic [31:0] rd, input int dly);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!hsel_o && n < 8);
    chk("issue_latency", n, 1);
    chk("issue_gnt", {28'd0, gnt_o}, 32'd1 << w);
    chk("issue_hready_o", {31'd0, hready_o}, 32'd1);
    chk("issue_haddr", {24'd0, haddr_o}, {24'd0, t_addr[w]});
    chk("issue_hwrite", {31'd0, hwrite_o}, {31'd0, t_wr[w]});
    chk("issue_done", {28'd0, done_o}, 32'd0);
    // Bridge claims ready during the first WAIT cycle; the arbiter must ignore it
    step();
    chk("wait_hsel_hready", {30'd0, hsel_o, hready_o}, 32'd0);
    chk("wait_hwdata", hwdata_o, t_wd[w]);
    hready_i = 1'b1;
    hrdata_i = rd;
    step();
    chk("first_wait_ignored", {28'd0, done_o}, 32'd0);
    for (int k = 0; k < dly; k++) begin
      hready_i = 1'b0;
      step();
      chk("wait_hold_done", {28'd0, done_o}, 32'd0);
      chk("wait_hold_hwdata", hwdata_o, t_wd[w]);
      chk("wait_hold_haddr", {24'd0, haddr_o}, {24'd0, t_addr[w]});
    end
    hready_i = 1'b1;
    step();
    hready_i = 1'b0;
    hrdata_i = 32'h0;
    chk("resp_done", {28'd0, done_o}, 32'd1 << w);
    chk("resp_gnt", {28'd0, gnt_o}, 32'd1 << w);
    chk("resp_rdata", rdata_o, t_wr[w] ? 32'd0 : rd);
    chk("resp_err", {31'd0, err_o}, 32'd0);
    step();
    chk("idle_done", {28'd0, done_o}, 32'd0);
    chk("idle_gnt", {28'd0, gnt_o}, 32'd0);
  endtask

  initial begin
    t_addr[0] = 8'h10; t_wr[0] = 1'b0; t_wd[0] = 32'hA0A0_0000;
    t_addr[1] = 8'h14; t_wr[1] = 1'b1; t_wd[1] = 32'h1111_2222;
    t_addr[2] = 8'h24; t_wr[2] = 1'b1; t_wd[2] = 32'h1234_5678;
    t_addr[3] = 8'h38; t_wr[3] = 1'b0; t_wd[3] = 32'hCAFE_F00D;
    rst_n_i  = 1'b0;
    req_i    = 4'b0000;
    hready_i = 1'b0;
    hrdata_i = 32'h0;
    repeat (2) step();
    chk_all_zero("reset");
    rst_n_i = 1'b1;
    step();
    chk_all_zero("idle_no_req");

    // Single read from requester 0
    req_i = 4'b0001;
    serve(0, 32'hDEAD_BEEF, 0);
    req_i = 4'b0000;

    // Single write from requester 2 with a slow bridge
    req_i = 4'b0100;
    serve(2, 32'h5555_AAAA, 3);
    req_i = 4'b0000;

    // Reset during WAIT clears outputs immediately, then requester 0 wins first
    req_i = 4'b0010;
    step();
    chk("pre_reset_issue", {31'd0, hsel_o}, 32'd1);
    step();
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2;
    rst_n_i = 1'b1;
    req_i = 4'b1111;

    // All four pending: strict rotation 0,1,2,3,0,1
    serve(0, 32'h0000_0100, 0);
    serve(1, 32'h0000_0101, 1);
    serve(2, 32'h0000_0102, 0);
    serve(3, 32'h0000_0103, 2);
    serve(0, 32'h0000_0104, 0);
    serve(1, 32'h0000_0105, 0);
    req_i = 4'b0000;

    // Fairness: 0 and 3 alternate; raising 1 after 3 slots it in after 0
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    req_i = 4'b1001;
    serve(0, 32'h0000_0200, 0);
    serve(3, 32'h0000_0203, 0);
    req_i = 4'b1011;
    serve(0, 32'h0000_0210, 0);
    serve(1, 32'h0000_0211, 0);
    serve(3, 32'h0000_0213, 0);
    serve(0, 32'h0000_0220, 0);
    req_i = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // Stalled bridge: 16 WAIT cycles then an aborted completion
    begin
      int n;
      req_i = 4'b0001;
      step();
      chk("tmo_issue", {31'd0, hsel_o}, 32'd1);
      req_i = 4'b0000;
      n = 0;
      do begin
        step();
        n++;
      end while (done_o == 4'b0000 && n < 40);
      chk("tmo_cycles", n, 17);
      chk("tmo_done", {28'd0, done_o}, 32'd1);
      chk("tmo_err", {31'd0, err_o}, 32'd1);
      chk("tmo_rdata", rdata_o, 32'd0);
      step();
      chk("tmo_idle_err", {31'd0, err_o}, 32'd0);
      chk("tmo_idle_gnt", {28'd0, gnt_o}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
